// File: rtl/sum_block_avg.sv
// Block statistics for the adder's sum stream: gathers 2**LOG2_N accepted samples,
// then presents truncated mean, min, max and a running block count until taken.
module sum_block_avg #(
    parameter int IN_W   = 6,
    parameter int LOG2_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IN_W-1:0]   out_avg,
    output logic [IN_W-1:0]   out_min,
    output logic [IN_W-1:0]   out_max,
    output logic [CNT_W-1:0]  out_blocks
);

    localparam int ACC_W = IN_W + LOG2_N;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on state, never on in_valid or out_ready.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [LOG2_N-1:0] count;
    logic [IN_W-1:0]   run_min;
    logic [IN_W-1:0]   run_max;
    logic [IN_W-1:0]   min_next;
    logic [IN_W-1:0]   max_next;
    logic              accept;
    logic              last;
    logic              take;

    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign last     = (count == {LOG2_N{1'b1}});
    assign acc_sum  = acc + ACC_W'(in_data);
    assign min_next = (in_data < run_min) ? in_data : run_min;
    assign max_next = (in_data > run_max) ? in_data : run_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Results are latched from the combinational next values so the final
    // sample of the block is included without an extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            count      <= '0;
            run_min    <= '1;
            run_max    <= '0;
            out_avg    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_blocks <= '0;
        end else if (accept) begin
            acc     <= acc_sum;
            count   <= count + LOG2_N'(1);
            run_min <= min_next;
            run_max <= max_next;
            if (last) begin
                out_avg    <= acc_sum[ACC_W-1:LOG2_N];
                out_min    <= min_next;
                out_max    <= max_next;
                out_blocks <= out_blocks + CNT_W'(1);
            end
        end else if (take) begin
            acc     <= '0;
            count   <= '0;
            run_min <= '1;
            run_max <= '0;
        end
    end

endmodule
